// File: rtl/dtmf_tone_sequencer.sv
// DTMF-style tone sequencer: takes one BCD digit per handshake and plays a
// row/column square-wave pair for a fixed burst length, then a silent gap.
// Counts digits toned and flags non-dialable codes.
module dtmf_tone_sequencer #(
  parameter int TONE_CYCLES = 64,
  parameter int GAP_CYCLES  = 32
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_digit_in,
  input  logic       i_digit_valid,
  output logic       o_digit_ready,
  output logic       o_row_sq,
  output logic       o_col_sq,
  output logic       o_tone_active,
  output logic [3:0] o_cur_digit,
  output logic       o_digit_err,
  output logic [7:0] o_digits_sent
);

  // One duration counter serves both the burst and the gap.
  localparam int MAX_CYC = (TONE_CYCLES > GAP_CYCLES) ? TONE_CYCLES : GAP_CYCLES;
  localparam int CW      = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] TONE_LOAD = CW'(TONE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TONE = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_dur_cnt;
  logic [3:0]    r_row_cnt;
  logic [3:0]    r_col_cnt;
  logic [3:0]    r_row_reload;
  logic [3:0]    r_col_reload;
  logic          r_row_sq;
  logic          r_col_sq;
  logic          r_tone_active;
  logic [3:0]    r_cur_digit;
  logic          r_digit_err;
  logic [7:0]    r_digits_sent;
  logic          w_accept;
  logic          w_valid_code;

  // Row half-period minus one: rows 0..3 have half-periods 12, 11, 10, 9.
  function automatic logic [3:0] row_reload(input logic [3:0] d);
    case (d)
      4'd1, 4'd2, 4'd3: row_reload = 4'd11;
      4'd4, 4'd5, 4'd6: row_reload = 4'd10;
      4'd7, 4'd8, 4'd9: row_reload = 4'd9;
      4'd0:             row_reload = 4'd8;
      default:          row_reload = 4'd11;
    endcase
  endfunction

  // Column half-period minus one: columns 0..2 have half-periods 7, 6, 5.
  function automatic logic [3:0] col_reload(input logic [3:0] d);
    case (d)
      4'd1, 4'd4, 4'd7:       col_reload = 4'd6;
      4'd2, 4'd5, 4'd8, 4'd0: col_reload = 4'd5;
      4'd3, 4'd6, 4'd9:       col_reload = 4'd4;
      default:                col_reload = 4'd6;
    endcase
  endfunction

  assign w_accept     = i_digit_valid & o_digit_ready;
  assign w_valid_code = (i_digit_in <= 4'd9);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: burst and gap end when the duration counter hits zero.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_valid_code) begin
          w_next_state = S_TONE;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_TONE: begin
        if (r_dur_cnt == '0) begin
          w_next_state = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end else begin
          w_next_state = S_TONE;
        end
      end
      S_GAP: begin
        if (r_dur_cnt == '0) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_GAP;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Ready is the only combinational output: idle and not being reset.
  always_comb begin
    if ((r_state == S_IDLE) && !i_rst) begin
      o_digit_ready = 1'b1;
    end else begin
      o_digit_ready = 1'b0;
    end
  end

  // Datapath: digit latch, wave generators, duration counter, counters, error pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dur_cnt     <= '0;
      r_row_cnt     <= 4'd0;
      r_col_cnt     <= 4'd0;
      r_row_reload  <= 4'd0;
      r_col_reload  <= 4'd0;
      r_row_sq      <= 1'b0;
      r_col_sq      <= 1'b0;
      r_tone_active <= 1'b0;
      r_cur_digit   <= 4'd0;
      r_digit_err   <= 1'b0;
      r_digits_sent <= 8'd0;
    end else begin
      r_digit_err <= w_accept & ~w_valid_code;
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_valid_code) begin
            r_cur_digit   <= i_digit_in;
            r_row_reload  <= row_reload(i_digit_in);
            r_col_reload  <= col_reload(i_digit_in);
            r_row_cnt     <= row_reload(i_digit_in);
            r_col_cnt     <= col_reload(i_digit_in);
            r_row_sq      <= 1'b1;
            r_col_sq      <= 1'b1;
            r_tone_active <= 1'b1;
            r_dur_cnt     <= TONE_LOAD;
          end
        end
        S_TONE: begin
          if (r_dur_cnt == '0) begin
            r_tone_active <= 1'b0;
            r_row_sq      <= 1'b0;
            r_col_sq      <= 1'b0;
            r_digits_sent <= r_digits_sent + 8'd1;
            r_dur_cnt     <= GAP_LOAD;
          end else begin
            r_dur_cnt <= r_dur_cnt - 1'b1;
            // Row and column waves run independently off their own counters.
            if (r_row_cnt == 4'd0) begin
              r_row_sq  <= ~r_row_sq;
              r_row_cnt <= r_row_reload;
            end else begin
              r_row_cnt <= r_row_cnt - 4'd1;
            end
            if (r_col_cnt == 4'd0) begin
              r_col_sq  <= ~r_col_sq;
              r_col_cnt <= r_col_reload;
            end else begin
              r_col_cnt <= r_col_cnt - 4'd1;
            end
          end
        end
        S_GAP: begin
          if (r_dur_cnt != '0) begin
            r_dur_cnt <= r_dur_cnt - 1'b1;
          end
        end
        default: begin
          r_tone_active <= 1'b0;
        end
      endcase
    end
  end

  assign o_row_sq      = r_row_sq;
  assign o_col_sq      = r_col_sq;
  assign o_tone_active = r_tone_active;
  assign o_cur_digit   = r_cur_digit;
  assign o_digit_err   = r_digit_err;
  assign o_digits_sent = r_digits_sent;

endmodule

// File: doc/dtmf_tone_sequencer.md
# dtmf_tone_sequencer

Downstream consumer of the phone-number counter's digit stream. It accepts one BCD digit at a time over a valid/ready handshake and emits a DTMF-style pair of square waves for that digit: one row tone and one column tone. Each tone burst has a fixed length and is followed by a fixed silent gap. It also counts the digits dialled and flags non-dialable codes.

## Interface
- TONE_CYCLES, default 64: clock cycles per tone burst; legal range ≥1.
- GAP_CYCLES, default 32: silent cycles after each burst; 0 is legal and means no gap.
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- digit_in  in  4  digit code from the upstream counter; 0–9 valid, 10–15 invalid.
- digit_valid  in  1  upstream presents digit_in.
- digit_ready  out  1  sequencer can accept; high only in IDLE and not in reset.
- row_sq  out  1  row-tone square wave.
- col_sq  out  1  column-tone square wave.
- tone_active  out  1  high for every cycle of a tone burst.
- cur_digit  out  4  digit currently being sent; holds its value through the gap and IDLE.
- digit_err  out  1  one-cycle pulse when an invalid code is accepted.
- digits_sent  out  8  number of valid digits fully toned; wraps from 255 to 0.

## Operation
- States: IDLE, TONE, GAP.
- Accept condition: digit_valid && digit_ready at a rising edge of clk.
- IDLE, valid digit accepted:
  - latch cur_digit;
  - look up row and column;
  - go to TONE.
- IDLE, invalid digit (10–15) accepted:
  - digit_err=1 in the next cycle only;
  - stay in IDLE; digit_ready remains 1;
  - cur_digit and digits_sent are unchanged.
- Digit map (row, col):
  - 1/2/3 → (0, 0/1/2)
  - 4/5/6 → (1, 0/1/2)
  - 7/8/9 → (2, 0/1/2)
  - 0 → (3, 1)
- Half-periods in clk cycles, fixed constants:
  - rows 0–3: 12, 11, 10, 9;
  - columns 0–2: 7, 6, 5.
- TONE behaviour:
  - on entry, row_sq=col_sq=1 and each phase counter loads half-period−1;
  - each counter decrements every cycle; when it reaches 0 its output toggles and the counter reloads;
  - the two waves run independently.
- TONE length: exactly TONE_CYCLES cycles, then go to GAP. If GAP_CYCLES=0, go to IDLE instead.
- digits_sent increments on the edge that leaves TONE.
- GAP: row_sq=col_sq=0 and tone_active=0 for exactly GAP_CYCLES cycles, then IDLE.
- digit_valid is ignored outside IDLE. Upstream must hold the digit; nothing is buffered.
- rst in any state:
  - next cycle is IDLE;
  - all outputs 0 except digit_ready, which returns to 1 in the first cycle after rst falls;
  - an in-progress burst or gap is abandoned and not counted.

## Timing
- Reset values: row_sq=0, col_sq=0, tone_active=0, cur_digit=0, digit_err=0, digits_sent=0, digit_ready=0 while rst=1.
- Acceptance latency:
  - accept at edge k;
  - tone_active=1 in cycles k+1 … k+TONE_CYCLES;
  - GAP occupies the next GAP_CYCLES cycles;
  - digit_ready=1 again from cycle k+TONE_CYCLES+GAP_CYCLES+1.
- Minimum digit period: TONE_CYCLES+GAP_CYCLES+1 cycles (default 97).
- First row toggle: for row half-period H, row_sq first goes low at cycle k+1+H. col_sq follows the same rule with its own half-period.
- digit_ready is combinational from state and rst. All other outputs are registered.
- digit_err is registered and asserts one cycle after the accepting edge.

## Test plan
- Reset: hold rst for 10 cycles with digit_valid=1 → all outputs 0, digit_ready=0. After release, digit_ready=1 and nothing is accepted while in reset.
- Digit 5 with defaults:
  - tone_active high for exactly 64 cycles;
  - row_sq toggles every 11 cycles and col_sq every 6 cycles, first falling at accept+12 and accept+7;
  - digit_ready returns at accept+97;
  - digits_sent=1.
- Digit 0 then digit 9 back-to-back, digit_valid held high: the second digit is accepted exactly at the first accept+97; row/col are (3,1) then (2,2); digits_sent=2.
- digit_in=12 in IDLE → digit_err pulses exactly 1 cycle; no tone; digits_sent unchanged; digit 1 offered on the very next cycle is accepted.
- GAP_CYCLES=0, TONE_CYCLES=4 → digit_ready reasserts at accept+5. 256 valid digits make digits_sent wrap to 0.
- rst asserted mid-TONE at cycle accept+30 → next cycle is IDLE with outputs 0 and digits_sent unchanged; a new digit is accepted after release.
